// File: rtl/rw_arbiter.sv
// rtl/rw_arbiter.sv - two-requester round-robin arbiter for a single memory port
// Winner's command is latched at grant; the access ends on mem_ready or after TIMEOUT cycles.
module rw_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          wr_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          wr_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          done_a,
  output logic          done_b,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] DONE   = 2'b10;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          ptr;          // 0 = A has priority, 1 = B has priority
  logic [CW-1:0] cnt;
  logic          pick_a;
  logic          timeout_hit;

  assign pick_a      = req_a && (!req_b || !ptr);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = (req_a || req_b) ? ACCESS : IDLE;
      ACCESS:  state_nxt = (mem_ready || timeout_hit) ? DONE : ACCESS;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en = (state == ACCESS);
    done_a = (state == DONE) && gnt_a;
    done_b = (state == DONE) && gnt_b;
  end

  // Grant, command latch, completion status and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= 1'b0;
      cnt       <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            gnt_a     <= pick_a;
            gnt_b     <= !pick_a;
            mem_we    <= pick_a ? wr_a    : wr_b;
            mem_addr  <= pick_a ? addr_a  : addr_b;
            mem_wdata <= pick_a ? wdata_a : wdata_b;
            cnt       <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + CW'(1);
          if (mem_ready) begin
            if (!mem_we) rdata <= mem_rdata;
            err <= 1'b0;
          end else if (timeout_hit) begin
            err <= 1'b1;
          end
        end
        DONE: begin
          ptr   <= gnt_a;
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
        end
        default: begin
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
        end
      endcase
    end
  end

endmodule
